pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage core. It arbitrates stall, bubble and redirect requests from the ID, EX and MEM stages. Each cycle it drives the per-stage load enables and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences multi-cycle stalls, keeps pending redirects across memory stalls and counts stall cycles.

## Interface
- Parameters:
- `ADDR_W`, 32: instruction address width (`InstAddrBus`).
- `CNT_W`, 32: stall counter width.
- Ports:
- `clk` in 1: core clock.
- `rstn` in 1: asynchronous, active-low reset.
- `ld_use_i` in 1: load-use hazard detected in ID.
- `ex_busy_i` in 1: multi-cycle EX unit (mul/div) busy, level.
- `mem_busy_i` in 1: LSU waiting on the data bus, level.
- `jump_i` in 1: EX redirect, one-cycle pulse per taken branch/jump.
- `jump_addr_i` in ADDR_W: redirect target, valid with `jump_i`.
- `hold_en_o` out 5: per-stage load enable, 1 = register captures. Bits: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb.
- `flush_o` out 5: per-stage bubble, 1 = register loads `INST_NOP`/invalid. Same bit map.
- `jump_o` out 1: PC redirect strobe.
- `jump_addr_o` out ADDR_W: redirect target.
- `stall_cnt_o` out CNT_W: saturating count of cycles with `hold_en_o[0]`=0.

## Operation
- FSM states: RUN, MSTALL, XSTALL. IRQ_DRAIN exists only with the macro.
- Combinational priority within a cycle, highest first:
  1. mem_busy: `hold_en_o`=5'b10000, `flush_o`=5'b10000 (MEM/WB gets a bubble).
  2. ex_busy: `hold_en_o`=5'b11000, `flush_o`=5'b01000.
  3. jump (live or pending): `hold_en_o`=5'b11111, `flush_o`=5'b00110, `jump_o`=1.
  4. ld_use: `hold_en_o`=5'b11100, `flush_o`=5'b00100.
  5. Otherwise: `hold_en_o`=5'b11111, `flush_o`=0.
- Jump beats ld_use in the same cycle, because the ld_use instruction is on the wrong path.
- FSM transitions:
  - RUN to MSTALL on `mem_busy_i`.
  - RUN to XSTALL on `ex_busy_i` with `mem_busy_i`=0.
  - MSTALL/XSTALL return to RUN on the first cycle their busy input is low.
  - MSTALL to XSTALL if `mem_busy_i` drops while `ex_busy_i`=1.
- Pending redirect: when `jump_i` arrives while mem_busy or ex_busy is active, `jump_addr_i` is latched into `pend_addr` and `pend_vld` is set. `jump_o` asserts in the first non-stalled cycle with `jump_addr_o`=`pend_addr`, and `pend_vld` then clears.
- A second `jump_i` while `pend_vld`=1 overwrites `pend_addr` (youngest wins).
- `jump_o`/`jump_addr_o` are combinational from the live `jump_i` or the pending register.
- Stall counter: increments by 1 whenever `hold_en_o[0]`=0 and saturates at all-ones (no wrap).

## Timing
- Reset values:
  - FSM=RUN, `pend_vld`=0, `pend_addr`=0, `stall_cnt_o`=0.
  - `hold_en_o`=5'b11111, `flush_o`=0, `jump_o`=0, `jump_addr_o`=0.
- Stall/flush/redirect outputs have zero-cycle latency from the inputs; stage registers act on the next clk edge.
- ld_use gives exactly one bubble per assertion cycle.
- Release: the first cycle after busy falls shows RUN encoding (or the pending jump).
- Reset mid-stall drops the FSM to RUN and discards the pending redirect.

## Configuration
- `PIPE_CTRL_IRQ_EN`: adds these ports:
  - `irq_i` in 1: level request.
  - `irq_vec_i` in ADDR_W: handler address.
  - `irq_ack_o` out 1: one-cycle acknowledge.
- IRQ_DRAIN sequence:
  - An IRQ is accepted in RUN when no stall, jump or pending jump is active.
  - The FSM enters IRQ_DRAIN with `hold_en_o`=5'b11110 and `flush_o`=5'b00010 for 3 cycles (2-bit drain counter).
  - It then asserts `jump_o` with `jump_addr_o`=`irq_vec_i` and `irq_ack_o`=1, and returns to RUN.
  - mem_busy during the drain freezes the drain counter.
  - A jump during the drain is discarded.
- Without the macro, the ports, state and counter are absent and `irq` has no effect.

## Structure
- Shared defines:
  - stage index constants (`STG_PC`..`STG_WB`).
  - FSM state encodings.
  - the `INST_NOP` reference.
  - `InstAddrBus`.
- State, `pend_*` and the counter use `gnrl_dfflr` instances.
- One sub-module, `stall_cnt`: a parameterised saturating counter.

## Test plan
- Reset with all inputs 0: `hold_en_o`=5'b11111, `flush_o`=0, `stall_cnt_o`=0.
- `ld_use_i`=1 for 1 cycle: `hold_en_o`=5'b11100, `flush_o`=5'b00100; `stall_cnt_o`=1 the next cycle.
- `jump_i`=1 with `jump_addr_i`=0x80, together with `ld_use_i`=1: `jump_o`=1, `jump_addr_o`=0x80, `flush_o`=5'b00110.
- `mem_busy_i` high for 4 cycles with `jump_i` 0x100 pulsed in cycle 2: `hold_en_o`=5'b10000 for all 4 cycles; the fifth cycle shows `jump_o`=1 and `jump_addr_o`=0x100.
- `ex_busy_i` high 3 cycles overlapping `mem_busy_i` in cycle 1: state goes MSTALL, XSTALL, XSTALL, RUN; the counter saturates when preloaded near all-ones.
- With the macro, `irq_i`=1 and `irq_vec_i`=0x40 in RUN: 3 drain cycles, then `jump_o`=1, `jump_addr_o`=0x40, `irq_ack_o`=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices, encodings and FSM states for pipe_ctrl
// IRQ_DRAIN state present only with PIPE_CTRL_IRQ_EN
package pipe_ctrl_pkg;

  localparam int          INST_ADDR_W = 32;             // InstAddrBus
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;  // addi x0, x0, 0

  localparam int NSTG       = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_WB     = 4;

  localparam logic [NSTG-1:0] HOLD_ALL    = 5'b11111;
  localparam logic [NSTG-1:0] HOLD_MEM    = 5'b10000;
  localparam logic [NSTG-1:0] HOLD_EX     = 5'b11000;
  localparam logic [NSTG-1:0] HOLD_LDUSE  = 5'b11100;
  localparam logic [NSTG-1:0] HOLD_DRAIN  = 5'b11110;
  localparam logic [NSTG-1:0] FLUSH_NONE  = 5'b00000;
  localparam logic [NSTG-1:0] FLUSH_MEM   = 5'b10000;
  localparam logic [NSTG-1:0] FLUSH_EX    = 5'b01000;
  localparam logic [NSTG-1:0] FLUSH_JUMP  = 5'b00110;
  localparam logic [NSTG-1:0] FLUSH_LDUSE = 5'b00100;
  localparam logic [NSTG-1:0] FLUSH_DRAIN = 5'b00010;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MSTALL = 2'd1,
    ST_XSTALL = 2'd2
`ifdef PIPE_CTRL_IRQ_EN
    , ST_IRQ_DRAIN = 2'd3
`endif
  } state_e;

  localparam logic [1:0] DRAIN_LAST = 2'd3;

endpackage

// File: rtl/pipe_ctrl_gnrl_dfflr.sv
// rtl/pipe_ctrl_gnrl_dfflr.sv - load-enabled flop with async active-low reset to zero
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden_i,
  input  logic [DW-1:0] dnxt_i,
  output logic [DW-1:0] qout_o
);

  logic [DW-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (lden_i) begin
      data_q <= dnxt_i;
    end
  end

  assign qout_o = data_q;

endmodule

// File: rtl/pipe_ctrl_stall_cnt.sv
// rtl/pipe_ctrl_stall_cnt.sv - saturating up-counter, holds at all-ones
module stall_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         sat;

  assign sat   = &cnt_q;
  assign cnt_d = cnt_q + W'(1);

  gnrl_dfflr #(.DW(W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .lden_i (inc_i & ~sat),
    .dnxt_i (cnt_d),
    .qout_o (cnt_q)
  );

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/bubble/redirect arbiter for the five-stage core
// Optional IRQ drain sequence enabled by PIPE_CTRL_IRQ_EN
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_use_i,
  input  logic              ex_busy_i,
  input  logic              mem_busy_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [NSTG-1:0]   hold_en_o,
  output logic [NSTG-1:0]   flush_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
`ifdef PIPE_CTRL_IRQ_EN
  input  logic              irq_i,
  input  logic [ADDR_W-1:0] irq_vec_i,
  output logic              irq_ack_o,
`endif
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [1:0]        state_raw;
  state_e            state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              pend_set, pend_clr, stalled;
`ifdef PIPE_CTRL_IRQ_EN
  logic [1:0]        drain_q, drain_d;
`endif

  assign stalled = mem_busy_i | ex_busy_i;
  assign state_q = state_e'(state_raw);

  always_comb begin
    hold_en_o   = HOLD_ALL;
    flush_o     = FLUSH_NONE;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    pend_clr    = 1'b0;
    pend_set    = stalled & jump_i;
    state_d     = state_q;
`ifdef PIPE_CTRL_IRQ_EN
    irq_ack_o   = 1'b0;
    drain_d     = drain_q;
    // Redirects arriving mid-drain are on the interrupted path and are dropped
    if (state_q == ST_IRQ_DRAIN) pend_set = 1'b0;
`endif

    if (mem_busy_i) begin
      hold_en_o = HOLD_MEM;
      flush_o   = FLUSH_MEM;
    end else if (ex_busy_i) begin
      hold_en_o = HOLD_EX;
      flush_o   = FLUSH_EX;
`ifdef PIPE_CTRL_IRQ_EN
    end else if (state_q == ST_IRQ_DRAIN) begin
      if (drain_q == DRAIN_LAST) begin
        flush_o     = FLUSH_JUMP;
        jump_o      = 1'b1;
        jump_addr_o = irq_vec_i;
        irq_ack_o   = 1'b1;
      end else begin
        hold_en_o = HOLD_DRAIN;
        flush_o   = FLUSH_DRAIN;
      end
`endif
    end else if (jump_i || pend_vld_q) begin
      // A live jump is younger than anything pending, so it takes the target
      flush_o     = FLUSH_JUMP;
      jump_o      = 1'b1;
      jump_addr_o = jump_i ? jump_addr_i : pend_addr_q;
      pend_clr    = pend_vld_q;
    end else if (ld_use_i) begin
      hold_en_o = HOLD_LDUSE;
      flush_o   = FLUSH_LDUSE;
    end

    case (state_q)
      ST_RUN: begin
        if (mem_busy_i) state_d = ST_MSTALL;
        else if (ex_busy_i) state_d = ST_XSTALL;
`ifdef PIPE_CTRL_IRQ_EN
        else if (irq_i && !jump_i && !pend_vld_q && !ld_use_i) begin
          state_d = ST_IRQ_DRAIN;
          drain_d = 2'd0;
        end
`endif
      end
      ST_MSTALL: if (!mem_busy_i) state_d = ex_busy_i ? ST_XSTALL : ST_RUN;
      ST_XSTALL: begin
        if (mem_busy_i) state_d = ST_MSTALL;
        else if (!ex_busy_i) state_d = ST_RUN;
      end
`ifdef PIPE_CTRL_IRQ_EN
      ST_IRQ_DRAIN: begin
        if (!stalled) begin
          if (drain_q == DRAIN_LAST) state_d = ST_RUN;
          else drain_d = drain_q + 2'd1;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  assign pend_vld_d = pend_set | (pend_vld_q & ~pend_clr);

  gnrl_dfflr #(.DW(2)) u_state (
    .clk(clk), .rst_n(rstn), .lden_i(1'b1), .dnxt_i(state_d), .qout_o(state_raw)
  );

  gnrl_dfflr #(.DW(1)) u_pend_vld (
    .clk(clk), .rst_n(rstn), .lden_i(1'b1), .dnxt_i(pend_vld_d), .qout_o(pend_vld_q)
  );

  gnrl_dfflr #(.DW(ADDR_W)) u_pend_addr (
    .clk(clk), .rst_n(rstn), .lden_i(pend_set), .dnxt_i(jump_addr_i), .qout_o(pend_addr_q)
  );

`ifdef PIPE_CTRL_IRQ_EN
  gnrl_dfflr #(.DW(2)) u_drain (
    .clk(clk), .rst_n(rstn), .lden_i(1'b1), .dnxt_i(drain_d), .qout_o(drain_q)
  );
`endif

  stall_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rstn),
    .inc_i (~hold_en_o[STG_PC]),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl (IRQ vectors with PIPE_CTRL_IRQ_EN)
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [1:0] S_RUN = 2'd0, S_MS = 2'd1, S_XS = 2'd2, S_DR = 2'd3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              ld_use_i = 1'b0, ex_busy_i = 1'b0, mem_busy_i = 1'b0, jump_i = 1'b0;
  logic [ADDR_W-1:0] jump_addr_i = '0;
  logic [4:0]        hold_en_o, flush_o;
  logic              jump_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              irq_drv = 1'b0;
  logic [ADDR_W-1:0] irq_vec = 32'h40;
`ifdef PIPE_CTRL_IRQ_EN
  logic              irq_ack_o;
`endif

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ld_use_i    (ld_use_i),
    .ex_busy_i   (ex_busy_i),
    .mem_busy_i  (mem_busy_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .hold_en_o   (hold_en_o),
    .flush_o     (flush_o),
    .jump_o      (jump_o),
    .jump_addr_o (jump_addr_o),
`ifdef PIPE_CTRL_IRQ_EN
    .irq_i       (irq_drv),
    .irq_vec_i   (irq_vec),
    .irq_ack_o   (irq_ack_o),
`endif
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             nm;
    logic [4:0]        hold;
    logic [4:0]        flush;
    logic              jo;
    logic [ADDR_W-1:0] ja;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        st;
    logic              ack;
  } exp_t;

  exp_t             sb[$];
  int               n_chk = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] mcnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue what the outputs must be
  task automatic step(input string nm, input logic rst, input logic ld, input logic ex,
                      input logic mem, input logic jmp, input logic [ADDR_W-1:0] ja,
                      input logic [4:0] h, input logic [4:0] f, input logic jo,
                      input logic [ADDR_W-1:0] jao, input logic [1:0] st,
                      input logic irq = 1'b0, input logic ack = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = ~rst; ld_use_i = ld; ex_busy_i = ex; mem_busy_i = mem;
    jump_i = jmp; jump_addr_i = ja; irq_drv = irq;
    if (rst) mcnt = '0;
    e.nm = nm; e.hold = h; e.flush = f; e.jo = jo; e.ja = jao;
    e.cnt = mcnt; e.st = st; e.ack = ack;
    sb.push_back(e);
    if (!rst && !h[0] && mcnt != '1) mcnt = mcnt + 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.nm, " hold_en"}, 64'(hold_en_o), 64'(e.hold));
        chk({e.nm, " flush"}, 64'(flush_o), 64'(e.flush));
        chk({e.nm, " jump_o"}, 64'(jump_o), 64'(e.jo));
        chk({e.nm, " jump_addr"}, 64'(jump_addr_o), 64'(e.ja));
        chk({e.nm, " stall_cnt"}, 64'(stall_cnt_o), 64'(e.cnt));
        chk({e.nm, " state"}, 64'(dut.state_q), 64'(e.st));
`ifdef PIPE_CTRL_IRQ_EN
        chk({e.nm, " irq_ack"}, 64'(irq_ack_o), 64'(e.ack));
`endif
      end
    end
  end

  initial begin : stim
    //         name          rst ld ex mem jmp addr     hold   flush  jo addr    state
    step("reset",       1, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
    step("idle",        0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
    step("ld_use",      0, 1, 0, 0, 0, 32'h0,   5'h1C, 5'h04, 0, 32'h0,   S_RUN);
    step("after_ld",    0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
    step("jmp_ld",      0, 1, 0, 0, 1, 32'h80,  5'h1F, 5'h06, 1, 32'h80,  S_RUN);
    step("mem1",        0, 0, 0, 1, 0, 32'h0,   5'h10, 5'h10, 0, 32'h0,   S_RUN);
    step("mem2_jmp",    0, 0, 0, 1, 1, 32'h100, 5'h10, 5'h10, 0, 32'h0,   S_MS);
    step("mem3",        0, 0, 0, 1, 0, 32'h0,   5'h10, 5'h10, 0, 32'h0,   S_MS);
    step("mem4",        0, 0, 0, 1, 0, 32'h0,   5'h10, 5'h10, 0, 32'h0,   S_MS);
    step("mem_release", 0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h06, 1, 32'h100, S_MS);
    step("pend_clear",  0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
    step("mx1",         0, 0, 1, 1, 0, 32'h0,   5'h10, 5'h10, 0, 32'h0,   S_RUN);
    step("x2_jmp",      0, 0, 1, 0, 1, 32'h200, 5'h18, 5'h08, 0, 32'h0,   S_MS);
    step("x3_jmp",      0, 0, 1, 0, 1, 32'h300, 5'h18, 5'h08, 0, 32'h0,   S_XS);
    step("x_release",   0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h06, 1, 32'h300, S_XS);
    step("x_run",       0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
    for (int i = 0; i < 10; i++)
      step("sat_ex",    0, 0, 1, 0, 0, 32'h0,   5'h18, 5'h08, 0, 32'h0,   (i == 0) ? S_RUN : S_XS);
    step("sat_release", 0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_XS);
    step("sat_idle",    0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
    step("rs_mem_jmp",  0, 0, 0, 1, 1, 32'hABC, 5'h10, 5'h10, 0, 32'h0,   S_RUN);
    step("rs_mem",      0, 0, 0, 1, 0, 32'h0,   5'h10, 5'h10, 0, 32'h0,   S_MS);
    step("rst_mid",     1, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
    step("post_rst",    0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
`ifdef PIPE_CTRL_IRQ_EN
    step("irq_accept",  0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN, 1'b1);
    for (int i = 0; i < 3; i++)
      step("irq_drain", 0, 0, 0, 0, 0, 32'h0,   5'h1E, 5'h02, 0, 32'h0,   S_DR);
    step("irq_jump",    0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h06, 1, 32'h40,  S_DR, 1'b0, 1'b1);
    step("irq_done",    0, 0, 0, 0, 0, 32'h0,   5'h1F, 5'h00, 0, 32'h0,   S_RUN);
`endif
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_scoreboard: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
